// File: rtl/mlp_pkg.sv
// Shared constants and FSM state encoding for the MLP batch sequencer.
package mlp_pkg;

    localparam int IDX_W = 10;  // sample index and counter width
    localparam int CLS_N = 10;  // number of classes, equals maxi width
    localparam int ANS_W = 80;  // raw MLP answer width (CLS_N x 8-bit scores)
    localparam int LBL_W = 4;   // label ROM data width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/mlp_batch_sequencer_if.sv
// MLP handshake and label ROM bus between the batch sequencer (master)
// and the MLP core plus label ROM (slave).
interface mlp_batch_sequencer_if;
    import mlp_pkg::*;

    logic             mlp_start;
    logic [IDX_W-1:0] mlp_index;
    logic             mlp_done;
    logic [CLS_N-1:0] mlp_maxi;
    logic [ANS_W-1:0] mlp_answer;
    logic [IDX_W-1:0] label_addr;
    logic [LBL_W-1:0] label_data;

    modport master (
        output mlp_start, mlp_index, label_addr,
        input  mlp_done, mlp_maxi, mlp_answer, label_data
    );

    modport slave (
        input  mlp_start, mlp_index, label_addr,
        output mlp_done, mlp_maxi, mlp_answer, label_data
    );

endinterface

// File: rtl/mlp_label_check.sv
// Decodes the golden label to one-hot and compares it with the MLP's maxi.
// Out-of-range labels and non-one-hot predictions never match.
module mlp_label_check
    import mlp_pkg::*;
(
    input  logic [LBL_W-1:0] label_i,
    input  logic [CLS_N-1:0] maxi_i,
    output logic             match_o
);

    logic [CLS_N-1:0] expect_onehot;
    logic             in_range;

    // Label decode and exact one-hot compare.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        expect_onehot = '0;
        in_range      = (label_i < LBL_W'(CLS_N));
        if (in_range) begin
            expect_onehot[label_i] = 1'b1;
        end
        match_o = in_range && (maxi_i == expect_onehot);
    end

endmodule

// File: rtl/mlp_batch_sequencer.sv
// Batch accuracy sequencer: walks sample indices 0..n-1, starts the MLP for
// each one, waits for a freshly raised done, compares the prediction with the
// label ROM and accumulates sample/correct counts.
// Optional watchdog: define MLP_SEQ_TIMEOUT_EN to abandon a sample after
// TIMEOUT cycles in WAIT and raise the sticky timeout_err flag.
module mlp_batch_sequencer
    import mlp_pkg::*;
`ifdef MLP_SEQ_TIMEOUT_EN
#(
    parameter int TIMEOUT = 4095
)
`endif
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [IDX_W-1:0]     num_samples,
    mlp_batch_sequencer_if.master mlp_bus,
    output logic                 busy,
    output logic                 finished,
    output logic [IDX_W-1:0]     sample_cnt,
    output logic [IDX_W-1:0]     correct_cnt,
    output logic [ANS_W-1:0]     last_answer,
    output logic                 timeout_err
);

    state_e           state_q;
    logic [IDX_W-1:0] n_q;
    logic [IDX_W-1:0] index_q;
    logic [IDX_W-1:0] sample_cnt_q;
    logic [IDX_W-1:0] correct_cnt_q;
    logic [ANS_W-1:0] last_answer_q;
    logic             start_q;
    logic             busy_q;
    logic             finished_q;
    logic             done_armed_q;  // set once done has been seen low in WAIT
    logic             match;

`ifdef MLP_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wdog_q;
    logic            timeout_err_q;
`endif

    mlp_label_check u_label_check (
        .label_i (mlp_bus.label_data),
        .maxi_i  (mlp_bus.mlp_maxi),
        .match_o (match)
    );

    // Sequencer FSM with registered outputs and counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q       <= ST_IDLE;
            n_q           <= '0;
            index_q       <= '0;
            sample_cnt_q  <= '0;
            correct_cnt_q <= '0;
            last_answer_q <= '0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            done_armed_q  <= 1'b0;
`ifdef MLP_SEQ_TIMEOUT_EN
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        n_q           <= num_samples;
                        index_q       <= '0;
                        sample_cnt_q  <= '0;
                        correct_cnt_q <= '0;
`ifdef MLP_SEQ_TIMEOUT_EN
                        timeout_err_q <= 1'b0;
`endif
                        if (num_samples == '0) begin
                            state_q    <= ST_DONE;
                            busy_q     <= 1'b0;
                            finished_q <= 1'b1;
                        end else begin
                            state_q    <= ST_ISSUE;
                            start_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            finished_q <= 1'b0;
                        end
                    end
                end

                ST_ISSUE: begin
                    // Start pulse lasts exactly this state; re-arm done detection.
                    start_q      <= 1'b0;
                    done_armed_q <= 1'b0;
`ifdef MLP_SEQ_TIMEOUT_EN
                    wdog_q       <= '0;
`endif
                    state_q      <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (!mlp_bus.mlp_done) begin
                        done_armed_q <= 1'b1;
                    end
                    if (done_armed_q && mlp_bus.mlp_done) begin
                        last_answer_q <= mlp_bus.mlp_answer;
                        state_q       <= ST_CHECK;
                    end
`ifdef MLP_SEQ_TIMEOUT_EN
                    else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                        // Abandon the sample: counted, never correct.
                        timeout_err_q <= 1'b1;
                        sample_cnt_q  <= sample_cnt_q + IDX_W'(1);
                        state_q       <= ST_NEXT;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
`endif
                end

                ST_CHECK: begin
                    sample_cnt_q  <= sample_cnt_q + IDX_W'(1);
                    correct_cnt_q <= correct_cnt_q + IDX_W'(match);
                    state_q       <= ST_NEXT;
                end

                ST_NEXT: begin
                    if (sample_cnt_q == n_q) begin
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        finished_q <= 1'b1;
                    end else begin
                        index_q <= index_q + IDX_W'(1);
                        start_q <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mlp_bus.mlp_start  = start_q;
    assign mlp_bus.mlp_index  = index_q;
    assign mlp_bus.label_addr = index_q;
    assign busy               = busy_q;
    assign finished           = finished_q;
    assign sample_cnt         = sample_cnt_q;
    assign correct_cnt        = correct_cnt_q;
    assign last_answer        = last_answer_q;
`ifdef MLP_SEQ_TIMEOUT_EN
    assign timeout_err        = timeout_err_q;
`else
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_batch_sequencer.sv
// Self-checking bench for mlp_batch_sequencer: stub MLP with programmable
// latency and stale-done behaviour, synchronous label ROM, and a scoreboard
// of expected per-sample results pushed at each start pulse.
module tb_mlp_batch_sequencer;
    import mlp_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic [IDX_W-1:0] num_samples;
    logic             busy;
    logic             finished;
    logic [IDX_W-1:0] sample_cnt;
    logic [IDX_W-1:0] correct_cnt;
    logic [ANS_W-1:0] last_answer;
    logic             timeout_err;

    mlp_batch_sequencer_if mlp_bus ();

`ifdef MLP_SEQ_TIMEOUT_EN
    mlp_batch_sequencer #(.TIMEOUT(20)) dut (
`else
    mlp_batch_sequencer dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .num_samples (num_samples),
        .mlp_bus     (mlp_bus),
        .busy        (busy),
        .finished    (finished),
        .sample_cnt  (sample_cnt),
        .correct_cnt (correct_cnt),
        .last_answer (last_answer),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    always @(posedge clk) cyc++;

    // Label ROM and stub prediction tables
    logic [LBL_W-1:0] lbl_tab  [1024];
    logic [CLS_N-1:0] maxi_tab [1024];

    task automatic set_default_tables();
        for (int i = 0; i < 1024; i++) begin
            lbl_tab[i]  = LBL_W'(i % 10);
            maxi_tab[i] = CLS_N'(1) << (i % 10);
        end
    endtask

    // Synchronous label ROM, one cycle read latency.
    always @(posedge clk) mlp_bus.label_data <= lbl_tab[mlp_bus.label_addr];

    // Stub MLP
    int               stub_lat   = 5;
    bit               stub_hold  = 1'b0;
    bit               stub_never = 1'b0;
    int               stub_cnt   = 0;
    bit               stub_busy  = 1'b0;
    logic [IDX_W-1:0] stub_idx;

    always @(negedge clk) begin
        if (rst) begin
            stub_busy          = 1'b0;
            mlp_bus.mlp_done   = 1'b0;
            mlp_bus.mlp_maxi   = '0;
            mlp_bus.mlp_answer = '0;
        end else if (mlp_bus.mlp_start) begin
            stub_busy = 1'b1;
            stub_cnt  = stub_lat;
            stub_idx  = mlp_bus.mlp_index;
            if (!stub_hold) mlp_bus.mlp_done = 1'b0;
        end else if (stub_busy) begin
            stub_cnt--;
            // In hold mode the previous done stays visible into WAIT.
            if (!stub_hold || stub_cnt <= stub_lat - 2) mlp_bus.mlp_done = 1'b0;
            if (stub_cnt == 0 && !stub_never) begin
                mlp_bus.mlp_done   = 1'b1;
                mlp_bus.mlp_maxi   = maxi_tab[stub_idx];
                mlp_bus.mlp_answer = {8{stub_idx}};
                stub_busy          = 1'b0;
            end
        end else if (!stub_hold) begin
            mlp_bus.mlp_done = 1'b0;
        end
    end

    // Scoreboard
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             exp_ok;
        logic [ANS_W-1:0] exp_ans;
        int               t_start;
    } sb_t;

    sb_t              sb_q[$];
    logic [IDX_W-1:0] exp_next_idx  = '0;
    int               start_seen    = 0;
    logic [IDX_W-1:0] prev_sample   = '0;
    logic [IDX_W-1:0] prev_correct  = '0;
    bit               check_latency = 1'b0;
    bit               exp_timeout   = 1'b0;

    function automatic logic exp_match(input logic [LBL_W-1:0] l, input logic [CLS_N-1:0] m);
        if (l >= LBL_W'(CLS_N)) return 1'b0;
        return ($countones(m) == 1) && (m[l] == 1'b1);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_sample  = '0;
            prev_correct = '0;
        end else begin
            if (mlp_bus.mlp_start) begin
                sb_t e;
                start_seen++;
                tests_run++;
                if (mlp_bus.mlp_index !== exp_next_idx || mlp_bus.label_addr !== exp_next_idx) begin
                    tests_failed++;
                    $display("FAIL start_index: index=%0d addr=%0d expected %0d",
                             mlp_bus.mlp_index, mlp_bus.label_addr, exp_next_idx);
                end
                e.idx     = exp_next_idx;
                e.exp_ok  = exp_timeout ? 1'b0 : exp_match(lbl_tab[exp_next_idx], maxi_tab[exp_next_idx]);
                e.exp_ans = {8{exp_next_idx}};
                e.t_start = cyc;
                sb_q.push_back(e);
                exp_next_idx = exp_next_idx + IDX_W'(1);
            end
            if (sample_cnt !== prev_sample) begin
                if (sample_cnt != '0) begin
                    tests_run++;
                    if (sb_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL sample_unexpected: sample_cnt=%0d with no sample outstanding", sample_cnt);
                    end else begin
                        sb_t              e;
                        logic [IDX_W-1:0] d;
                        e = sb_q.pop_front();
                        d = correct_cnt - prev_correct;
                        if (d !== IDX_W'(e.exp_ok) ||
                            (!exp_timeout && last_answer !== e.exp_ans) ||
                            (check_latency && (cyc - e.t_start) < stub_lat)) begin
                            tests_failed++;
                            $display("FAIL sample_result idx=%0d: correct_delta=%0d exp=%0d answer=%h exp=%h cycles=%0d min=%0d",
                                     e.idx, d, e.exp_ok, last_answer, e.exp_ans, cyc - e.t_start, stub_lat);
                        end
                    end
                end
                prev_sample  = sample_cnt;
                prev_correct = correct_cnt;
            end
        end
    end

    // Stimulus helpers
    task automatic start_batch(input int n);
        @(negedge clk);
        exp_next_idx = '0;
        start_seen   = 0;
        go           = 1'b1;
        num_samples  = IDX_W'(n);
        @(negedge clk);
        go           = 1'b0;
    endtask

    task automatic wait_finished(input int budget, input string name);
        for (int k = 0; k < budget && finished !== 1'b1; k++) @(negedge clk);
        tests_run++;
        if (finished !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_wait: finished=%b after %0d cycles, expected 1", name, finished, budget);
        end
    endtask

    // Tests
    task automatic test_reset();
        rst         = 1'b1;
        go          = 1'b0;
        num_samples = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, finished, sample_cnt, correct_cnt, timeout_err, mlp_bus.mlp_start} !== '0 ||
            mlp_bus.mlp_index !== '0 || last_answer !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b fin=%b s=%0d c=%0d err=%b start=%b idx=%0d ans=%h, expected all 0",
                     busy, finished, sample_cnt, correct_cnt, timeout_err, mlp_bus.mlp_start,
                     mlp_bus.mlp_index, last_answer);
        end
        rst = 1'b0;
    endtask

    task automatic test_batch3();
        start_batch(3);
        tests_run++;
        if (busy !== 1'b1 || finished !== 1'b0) begin
            tests_failed++;
            $display("FAIL batch3_busy: busy=%b finished=%b expected 1/0", busy, finished);
        end
        wait_finished(200, "batch3");
        tests_run++;
        if (sample_cnt !== 10'd3 || correct_cnt !== 10'd3 || start_seen != 3 || busy !== 1'b0 ||
            timeout_err !== 1'b0 || last_answer !== {8{10'd2}} || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL batch3_counts: s=%0d c=%0d starts=%0d busy=%b err=%b ans=%h expected 3/3/3/0/0/%h",
                     sample_cnt, correct_cnt, start_seen, busy, timeout_err, last_answer, {8{10'd2}});
        end
    endtask

    task automatic test_mismatch();
        lbl_tab[1]  = 4'd7;
        maxi_tab[1] = 10'h004;
        maxi_tab[2] = 10'h005;
        start_batch(3);
        wait_finished(200, "mismatch");
        tests_run++;
        if (sample_cnt !== 10'd3 || correct_cnt !== 10'd1) begin
            tests_failed++;
            $display("FAIL mismatch_counts: s=%0d c=%0d expected 3/1", sample_cnt, correct_cnt);
        end
        set_default_tables();
    endtask

    task automatic test_label_range();
        lbl_tab[0]  = 4'd12;
        maxi_tab[0] = 10'h000;
        start_batch(1);
        wait_finished(100, "label_range");
        tests_run++;
        if (sample_cnt !== 10'd1 || correct_cnt !== 10'd0) begin
            tests_failed++;
            $display("FAIL label_range_counts: s=%0d c=%0d expected 1/0", sample_cnt, correct_cnt);
        end
        set_default_tables();
    endtask

    task automatic test_stale_done();
        stub_hold     = 1'b1;
        check_latency = 1'b1;
        start_batch(3);
        wait_finished(200, "stale");
        tests_run++;
        if (sample_cnt !== 10'd3 || correct_cnt !== 10'd3 || start_seen != 3) begin
            tests_failed++;
            $display("FAIL stale_counts: s=%0d c=%0d starts=%0d expected 3/3/3", sample_cnt, correct_cnt, start_seen);
        end
        stub_hold     = 1'b0;
        check_latency = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_samples();
        start_batch(0);
        tests_run++;
        if (finished !== 1'b1 || busy !== 1'b0 || sample_cnt !== '0 || correct_cnt !== '0) begin
            tests_failed++;
            $display("FAIL zero_state: fin=%b busy=%b s=%0d c=%0d expected 1/0/0/0", finished, busy, sample_cnt, correct_cnt);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (start_seen != 0) begin
            tests_failed++;
            $display("FAIL zero_start: %0d start pulses, expected 0", start_seen);
        end
    endtask

    task automatic test_go_ignored();
        start_batch(5);
        repeat (10) @(negedge clk);
        go          = 1'b1;
        num_samples = 10'd2;
        @(negedge clk);
        go          = 1'b0;
        wait_finished(300, "go_ignored");
        tests_run++;
        if (sample_cnt !== 10'd5 || correct_cnt !== 10'd5 || start_seen != 5) begin
            tests_failed++;
            $display("FAIL go_ignored_counts: s=%0d c=%0d starts=%0d expected 5/5/5", sample_cnt, correct_cnt, start_seen);
        end
    endtask

    task automatic test_reset_mid_batch();
        start_batch(4);
        for (int k = 0; k < 200 && start_seen < 3; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        tests_run++;
        if (start_seen != 3 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_setup: starts=%0d busy=%b expected 3/1", start_seen, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, finished, sample_cnt, correct_cnt, timeout_err, mlp_bus.mlp_start} !== '0 ||
            mlp_bus.mlp_index !== '0 || last_answer !== '0) begin
            tests_failed++;
            $display("FAIL midrst_state: busy=%b fin=%b s=%0d c=%0d idx=%0d ans=%h expected all 0",
                     busy, finished, sample_cnt, correct_cnt, mlp_bus.mlp_index, last_answer);
        end
        rst = 1'b0;
        start_batch(2);
        wait_finished(200, "midrst_rerun");
        tests_run++;
        if (sample_cnt !== 10'd2 || correct_cnt !== 10'd2 || start_seen != 2) begin
            tests_failed++;
            $display("FAIL midrst_rerun_counts: s=%0d c=%0d starts=%0d expected 2/2/2", sample_cnt, correct_cnt, start_seen);
        end
    endtask

`ifdef MLP_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        stub_never  = 1'b1;
        exp_timeout = 1'b1;
        start_batch(2);
        wait_finished(200, "timeout");
        tests_run++;
        if (timeout_err !== 1'b1 || sample_cnt !== 10'd2 || correct_cnt !== 10'd0 || finished !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_state: err=%b s=%0d c=%0d fin=%b expected 1/2/0/1",
                     timeout_err, sample_cnt, correct_cnt, finished);
        end
        stub_never  = 1'b0;
        exp_timeout = 1'b0;
    endtask
`endif

    initial begin
        set_default_tables();
        test_reset();
        test_batch3();
        test_mismatch();
        test_label_range();
        test_stale_done();
        test_zero_samples();
        test_go_ignored();
        test_reset_mid_batch();
`ifdef MLP_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete within 500000 time units");
        $fatal(1);
    end

endmodule

// File: doc/mlp_batch_sequencer.md
Name: mlp_batch_sequencer

Overview:
Host-side initiator for the MLP core's start/index/done/maxi/answer interface. It walks sample indices 0..num_samples-1 and, for each sample, pulses the MLP start and waits for the MLP done. It then compares the MLP's one-hot maxi against the golden label read from a synchronous label ROM and accumulates a correct-classification count. It sits beside MLP in the test/system top and drives batch-accuracy evaluation with no host involvement per sample.

Parameters:
IDX_W, 10, width of sample index and of all counters
CLS_N, 10, number of classes; equals the maxi width
ANS_W, 80, MLP answer width (CLS_N x 8-bit scores)
LBL_W, 4, label ROM data width (class id 0..CLS_N-1)
TIMEOUT, 4095, watchdog limit in cycles (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
go  in  1  one-cycle request to start a batch; sampled only in IDLE/DONE
num_samples  in  IDX_W  batch length; latched on an accepted go
mlp_start  out  1  one-cycle start pulse to MLP
mlp_index  out  IDX_W  sample index to MLP; stable from ISSUE until the next ISSUE
mlp_done  in  1  MLP completion; level, may stay high until the next start
mlp_maxi  in  CLS_N  MLP one-hot predicted class
mlp_answer  in  ANS_W  MLP raw output scores
label_addr  out  IDX_W  label ROM address; always equals mlp_index
label_data  in  LBL_W  label ROM data; synchronous read, 1-cycle latency
busy  out  1  high from an accepted go until DONE
finished  out  1  high in DONE until the next go or rst
sample_cnt  out  IDX_W  samples completed
correct_cnt  out  IDX_W  samples with a matching prediction
last_answer  out  ANS_W  mlp_answer captured at the last accepted done
timeout_err  out  1  sticky watchdog flag (0 when the feature is compiled out)

Behaviour:
- Reset (rst=1 at a clk edge, in any state, including mid-batch): state=IDLE. All outputs reset to 0: mlp_start, mlp_index, busy, finished, sample_cnt, correct_cnt, last_answer, timeout_err. The done_armed flag also resets to 0.
- FSM states: IDLE, ISSUE, WAIT, CHECK, NEXT, DONE.
- IDLE/DONE:
  - go=1: latch num_samples (n), clear both counters and timeout_err, set mlp_index=0.
  - If n==0, go directly to DONE (finished=1, busy=0).
  - Otherwise go to ISSUE, busy=1, finished=0.
  - go in any other state is ignored.
- ISSUE: mlp_start=1 for exactly this cycle; done_armed<=0; next state WAIT.
- WAIT:
  - done_armed<=1 on the first cycle mlp_done==0. A stale done held high from the previous sample is therefore never accepted.
  - When done_armed==1 and mlp_done==1: capture last_answer<=mlp_answer and go to CHECK.
  - label_data is already valid here because label_addr has been stable for at least 2 cycles.
- CHECK:
  - match = (label_data<CLS_N) and (mlp_maxi == 1<<label_data).
  - Non-one-hot maxi (zero or multiple bits set) counts as incorrect.
  - sample_cnt+1; correct_cnt+match; next state NEXT.
- NEXT:
  - If sample_cnt==n: go to DONE.
  - Otherwise mlp_index+1 and go to ISSUE.
- Per-sample overhead: 4 cycles plus the MLP latency plus 1 cycle of done-arm if the previous done is still high.
- Counters cannot wrap: n <= 2^IDX_W-1.

Optional Feature:
MLP_SEQ_TIMEOUT_EN
- Defined: a watchdog counter clears in ISSUE and increments each WAIT cycle. Reaching TIMEOUT sets timeout_err (sticky), counts the sample as incorrect (sample_cnt+1, no capture), and moves to NEXT.
- Undefined: no watchdog; WAIT waits indefinitely; timeout_err tied to 0.

Decomposition:
- Shared package mlp_pkg: IDX_W, CLS_N, ANS_W, LBL_W constants; FSM state enum (3-bit).
- One natural sub-module: mlp_label_check. Combinational label-to-one-hot decode, compare and range check producing match.

Test Plan:
- Batch of 3: stub MLP with a 5-cycle latency echoes maxi=1<<(index%10); labels = index%10. Required: 3 start pulses with index 0,1,2; finished=1; sample_cnt=3; correct_cnt=3.
- Mismatch and non-one-hot: label[1]=7 vs maxi=0x004; maxi=0x005 for sample 2; labels valid. Required: correct_cnt=1, sample_cnt=3.
- Stale done: stub holds mlp_done high until the next start. Required: each sample waits for a done low-then-high; no sample is completed in under the stub latency; counts as in the first scenario.
- num_samples=0: go. Required: finished=1 on the next cycle, no mlp_start pulse, counts 0. A second go during a running batch of 5 is ignored.
- Reset mid-batch: rst at sample 2 in WAIT. Required: next cycle all outputs 0 and state IDLE; a new go of 2 runs cleanly.
- Timeout (MLP_SEQ_TIMEOUT_EN defined): stub never raises done, TIMEOUT=20, n=2. Required: timeout_err=1, sample_cnt=2, correct_cnt=0, finished=1.
